// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver types, widths and baud divider helper.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
    localparam int BYTE_W = 8;
    localparam int BYTES_PER_WORD = 4;
    function automatic int calc_div(input int clk, input int baud, input int os);
        return (clk / (baud * os) < 1) ? 1 : clk / (baud * os);
    endfunction
endpackage

// File: rtl/uart_word_receiver_if.sv
// uart_word_receiver_if: serial line in, assembled word and status out.
interface uart_word_receiver_if;
    logic        RxD;
    logic [uart_pkg::BYTE_W*uart_pkg::BYTES_PER_WORD-1:0] dataOut;
    logic        dataValid;
    logic        frameErr;
    logic        busy;
    modport slave (input RxD, output dataOut, dataValid, frameErr, busy);
    modport master (output RxD, input dataOut, dataValid, frameErr, busy);
endinterface

// File: rtl/uart_oversample_tick.sv
// uart_oversample_tick: free-running divider giving one tick per OVERSAMPLE slot.
module uart_oversample_tick import uart_pkg::*; #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == CW'(DIV - 1);
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/uart_word_receiver.sv
// uart_word_receiver: 8N1 receiver packing 4 bytes LSB-first into 32-bit words.
// Optional RX_TIMEOUT_EN drops a partial word after TIMEOUT_BITS idle bit-times.
module uart_word_receiver import uart_pkg::*; #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 40
) (
    input logic clk,
    input logic rst,
    uart_word_receiver_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(BYTES_PER_WORD);
    localparam int WW = BYTE_W * BYTES_PER_WORD;
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    logic tick, rxs;
    rx_state_t state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [$clog2(BYTE_W)-1:0] bcnt_q, bcnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [WW-1:0] word_q, word_d, data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic valid_q, valid_d, ferr_q, ferr_d;
`ifdef RX_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_BITS * OVERSAMPLE);
    logic [TOW-1:0] to_q, to_d;
`endif
    uart_oversample_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .clk(clk), .rst(rst), .tick(tick)
    );
    assign rxs = sync_q[1];
    assign bus.dataOut = data_q;
    assign bus.dataValid = valid_q;
    assign bus.frameErr = ferr_q;
    assign bus.busy = state_q != IDLE;
    always_comb begin
        sync_d = {sync_q[0], bus.RxD};
        state_d = state_q;
        tcnt_d = tick ? tcnt_q + 1'b1 : tcnt_q;
        bcnt_d = bcnt_q;
        shreg_d = shreg_q;
        word_d = word_q;
        idx_d = idx_q;
        data_d = data_q;
        valid_d = 1'b0;
        ferr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (tick && !rxs) state_d = START;
            end
            START: if (tick && tcnt_q == HALF) begin
                state_d = rxs ? IDLE : DATA;
                tcnt_d = '0;
                bcnt_d = '0;
            end
            DATA: if (tick && tcnt_q == LAST) begin
                shreg_d = {rxs, shreg_q[BYTE_W-1:1]};
                bcnt_d = bcnt_q + 1'b1;
                state_d = (bcnt_q == '1) ? STOP : DATA;
            end
            STOP: if (tick && tcnt_q == LAST) begin
                // a bad stop bit poisons the whole word, not just this byte
                state_d = rxs ? IDLE : BREAK;
                ferr_d = !rxs;
                idx_d = rxs ? idx_q + 1'b1 : '0;
                word_d[BYTE_W*idx_q +: BYTE_W] = rxs ? shreg_q : word_q[BYTE_W*idx_q +: BYTE_W];
                valid_d = rxs && idx_q == IW'(BYTES_PER_WORD - 1);
                data_d = valid_d ? word_d : data_q;
            end
            BREAK: state_d = rxs ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
`ifdef RX_TIMEOUT_EN
        to_d = '0;
        if (state_q == IDLE && idx_q != '0) begin
            to_d = (tick && rxs) ? to_q + 1'b1 : (tick ? '0 : to_q);
            if (tick && rxs && to_q == TOW'(TIMEOUT_BITS * OVERSAMPLE - 1)) begin
                idx_d = '0;
                to_d = '0;
            end
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            state_q <= IDLE;
            tcnt_q <= '0;
            bcnt_q <= '0;
            shreg_q <= '0;
            word_q <= '0;
            idx_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            state_q <= state_d;
            tcnt_q <= tcnt_d;
            bcnt_q <= bcnt_d;
            shreg_q <= shreg_d;
            word_q <= word_d;
            idx_q <= idx_d;
            data_q <= data_d;
            valid_q <= valid_d;
            ferr_q <= ferr_d;
        end
    end
`ifdef RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        to_q <= rst ? '0 : to_d;
    end
`endif
endmodule

// File: tb/tb_uart_word_receiver.sv
// tb_uart_word_receiver: directed frames at 16 clk/bit with immediate-assertion checks.
module tb_uart_word_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, failures = 0;
    int nvalid = 0, nferr = 0, nboth = 0, nbad = 0;
    logic [31:0] last = '0, prev = '0;
    logic [7:0] b3;
    always #5 clk = ~clk;
    uart_word_receiver_if bus();
    uart_word_receiver #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .TIMEOUT_BITS(40)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always @(negedge clk) begin
        if (bus.dataValid) begin
            nvalid++;
            last = bus.dataOut;
        end
        if (bus.frameErr) nferr++;
        if (bus.dataValid && bus.frameErr) nboth++;
        if (bus.dataOut !== prev && !bus.dataValid && !rst) nbad++;
        prev = bus.dataOut;
    end
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] b, input int nstop = 1, input logic stopv = 1'b1);
        bus.RxD = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 8; i++) begin
            bus.RxD = b[i];
            wait_clk(16);
        end
        bus.RxD = stopv;
        wait_clk(16 * nstop);
        bus.RxD = 1'b1;
    endtask
    task automatic clr();
        nvalid = 0;
        nferr = 0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.RxD = 1'b1;
        wait_clk(3);
        check("rst_dataOut", bus.dataOut, 32'h0);
        check("rst_dataValid", {31'b0, bus.dataValid}, 32'h0);
        check("rst_frameErr", {31'b0, bus.frameErr}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        rst = 1'b0;
        wait_clk(20);
        clr();
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        wait_clk(20);
        check("t1_nvalid", nvalid, 1);
        check("t1_word", last, 32'h12345678);
        check("t1_ferr", nferr, 0);
        check("t1_hold", bus.dataOut, 32'h12345678);
        clr();
        for (int r = 0; r < 2; r++) begin
            send(8'hEF, 2); send(8'hBE, 2); send(8'hAD, 2); send(8'hDE, 2);
        end
        wait_clk(20);
        check("t2_nvalid", nvalid, 2);
        check("t2_word", last, 32'hDEADBEEF);
        check("t2_ferr", nferr, 0);
        clr();
        send(8'h9A);
        wait_clk(10);
        bus.RxD = 1'b0;
        wait_clk(5);
        check("t3_busy_hi", {31'b0, bus.busy}, 32'h1);
        bus.RxD = 1'b1;
        wait_clk(20);
        check("t3_busy_lo", {31'b0, bus.busy}, 32'h0);
        check("t3_ferr", nferr, 0);
        send(8'hBC); send(8'hDE); send(8'hF0);
        wait_clk(20);
        check("t3_nvalid", nvalid, 1);
        check("t3_word", last, 32'hF0DEBC9A);
        clr();
        send(8'h55); send(8'h66); send(8'h77, 1, 1'b0);
        bus.RxD = 1'b0;
        wait_clk(50);
        check("t4_ferr", nferr, 1);
        check("t4_break_busy", {31'b0, bus.busy}, 32'h1);
        check("t4_nvalid0", nvalid, 0);
        bus.RxD = 1'b1;
        wait_clk(10);
        check("t4_idle", {31'b0, bus.busy}, 32'h0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        wait_clk(20);
        check("t4_nvalid", nvalid, 1);
        check("t4_word", last, 32'h04030201);
        check("t4_ferr_once", nferr, 1);
        clr();
        send(8'hAA); send(8'hBB);
        b3 = 8'hCC;
        bus.RxD = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 4; i++) begin
            bus.RxD = b3[i];
            wait_clk(16);
        end
        bus.RxD = b3[4];
        wait_clk(8);
        rst = 1'b1;
        wait_clk(1);
        check("t5_rst_data", bus.dataOut, 32'h0);
        check("t5_rst_busy", {31'b0, bus.busy}, 32'h0);
        check("t5_rst_valid", {31'b0, bus.dataValid}, 32'h0);
        bus.RxD = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(40);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        wait_clk(20);
        check("t5_nvalid", nvalid, 1);
        check("t5_word", last, 32'hDDCCBBAA);
        check("t5_ferr", nferr, 0);
        clr();
        send(8'h5A);
        wait_clk(700);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_clk(20);
        check("t6_nvalid", nvalid, 1);
`ifdef RX_TIMEOUT_EN
        check("t6_word", last, 32'h44332211);
`else
        check("t6_word", last, 32'h3322115A);
`endif
        check("excl_valid_ferr", nboth, 0);
        check("dataOut_stable", nbad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
